// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared display package: BCD digit constants and converter state encoding.
// Imported by the binary-to-BCD converter and its digit-adjust cell.
package bin_to_bcd_seq_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  // Largest value representable in n decimal digits.
  function automatic int unsigned max_dec(input int n);
    int unsigned v;
    v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake bundle for the binary-to-BCD converter.
// The requester uses master, the converter uses slave.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is >= 5.
// Purely combinational; the carry out of the digit is dropped.
module bcd_digit_adjust
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= ADJ_THRESH) q = d + ADJ_ADD;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to packed BCD converter, one bit per clock.
// Results saturate to all nines when the input exceeds the digit range.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input logic             clk,
  input logic             rst,
  bin_to_bcd_seq_if.slave io
);

  localparam int SW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W);
  localparam int WW = SW + BIN_W;

  localparam logic [CW-1:0] LAST  = CW'(BIN_W - 1);
  localparam logic [31:0]   MAXV  = 32'(max_dec(DIGITS));
  localparam logic [SW-1:0] NINES = {DIGITS{4'h9}};

  state_t state, state_nx;

  logic [BIN_W-1:0] shift;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adj;
  logic [WW-1:0]    shifted;
  logic [CW-1:0]    cnt;
  logic             pend;
  logic             over;
  logic [SW-1:0]    bcd_q;
  logic             ovf_q;
  logic             done_q;
  logic             load;
  logic             step;
  logic             last;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (scratch[i*DIGIT_W +: DIGIT_W]),
      .q (adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted = {adj, shift} << 1;
  assign over    = {{(32-BIN_W){1'b0}}, io.bin} > MAXV;
  assign last    = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.start) state_nx = CONVERT;
      CONVERT: if (last)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    step    = 1'b0;
    io.busy = 1'b0;
    unique case (1'b1)
      (state == IDLE):    load = io.start;
      (state == CONVERT): begin
        step    = 1'b1;
        io.busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Published result only moves on the final step, never mid-conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      scratch <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        shift   <= io.bin;
        scratch <= '0;
        cnt     <= '0;
        pend    <= over;
      end else if (step) begin
        {scratch, shift} <= shifted;
        cnt <= cnt + CW'(1);
        if (last) begin
          bcd_q  <= pend ? NINES : shifted[WW-1 -: SW];
          ovf_q  <= pend;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign io.done     = done_q;
  assign io.bcd      = bcd_q;
  assign io.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq against a decimal reference model.
// Directed cases plus a randomized sweep over the full input range.
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int LAT    = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int x;
    if (v > 9999) return 16'h9999;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a conversion and follow it to done, checking result and timing.
  task automatic run_conv(input string tag, input int v, input bit chk_busy);
    int n;
    int bcnt;
    bit hold_ok;
    logic [15:0] prev;
    n = 0;
    while (bus.busy && n < 40) begin tick(); n++; end
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    prev = bus.bcd;
    bus.bin   = BIN_W'(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bin   = BIN_W'($urandom);
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    n = 0;
    bcnt = 0;
    hold_ok = 1'b1;
    while (!bus.done && n < 40) begin
      if (bus.busy) bcnt++;
      if (bus.bcd !== prev) hold_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk({tag, "_bcd"}, 32'(bus.bcd), 32'(ref_bcd(v)));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(v > 9999));
    chk({tag, "_hold"}, 32'(hold_ok), 32'd1);
    if (chk_busy) begin
      chk({tag, "_busycyc"}, 32'(bcnt), 32'(LAT));
      chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int dones;
    bus.start = 1'b0;
    bus.bin   = '0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd",  32'(bus.bcd),  32'd0);
    chk("rst_ovf",  32'(bus.overflow), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_conv("zero", 0, 1'b1);
    run_conv("d1234", 1234, 1'b0);
    run_conv("d9999", 9999, 1'b0);
    run_conv("b2b7", 7, 1'b0);
    run_conv("ov10000", 10000, 1'b0);
    run_conv("ov16383", 16383, 1'b0);
    run_conv("d42", 42, 1'b1);
    tick();
    chk("done_pulse", 32'(bus.done), 32'd0);

    // Second start while busy must be ignored.
    bus.bin   = BIN_W'(500);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin
        bus.bin   = BIN_W'(321);
        bus.start = 1'b1;
      end
      if (i == 4) bus.start = 1'b0;
      if (i > 4 && i < 12) bus.bin = BIN_W'($urandom);
      if (bus.done) begin
        dones++;
        chk("ign_bcd", 32'(bus.bcd), 32'h0500);
      end
      tick();
    end
    chk("ign_dones", 32'(dones), 32'd1);

    // Reset in the middle of a conversion.
    bus.bin   = BIN_W'(8765);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_bcd",  32'(bus.bcd),  32'd0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) dones++;
      tick();
    end
    chk("abort_nodone", 32'(dones), 32'd0);
    run_conv("d8765", 8765, 1'b1);

    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(0, 16383));
      if (i % 8 == 0) n = 9990 + int'($urandom_range(0, 20));
      run_conv("rnd", n, 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It produces the packed BCD digits consumed by the per-digit 7-segment decoders. Its main use is turning the game's binary score counter into displayable decimal digits. It uses a start/busy/done handshake so the score logic can request conversions at any time without stalling the display.

Parameters:
BIN_W, 14, width of the binary input (14 bits covers 0..9999).
DIGITS, 4, number of BCD digits produced.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion of bin; sampled only when not busy
bin  input  BIN_W  unsigned binary value, sampled on the accepted start edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd has just been updated
bcd  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0]; holds last result
overflow  output  1  flag for the last result, updated together with bcd

Behaviour:
- Reset (asynchronous, active-high): state IDLE; busy=0, done=0, bcd=0, overflow=0; internal shift and scratch registers cleared.
- States: IDLE, CONVERT.
- IDLE, start=1 at edge k:
  - Latch bin into the shift register, clear the scratch digits, clear the step counter.
  - Evaluate the saturation compare bin > 10^DIGITS-1 and store it as a pending overflow flag.
  - Set busy=1 and go to CONVERT.
- IDLE, start=0: no change, except done clears if it was set.
- CONVERT, every cycle:
  - Each scratch digit >= 5 gets +3 (4-bit, no carry out of the digit).
  - Then {scratch, shift} shifts left by 1; the counter increments.
- CONVERT, on the step with counter == BIN_W-1 (edge k+BIN_W):
  - bcd <= adjusted and shifted result, or all digits = 9 if the pending overflow flag is set.
  - overflow <= pending flag; done <= 1; busy <= 0; state goes to IDLE.
- Latency: done and the new bcd appear exactly BIN_W cycles after the start edge (14 at default). Throughput is one conversion per BIN_W cycles.
- done is high for exactly one cycle and is cleared on the following edge unconditionally.
- start while busy=1 is ignored, with no queuing. bin may change freely during CONVERT because only the latched copy is used.
- start in the same cycle done=1 (state is IDLE) is accepted: back-to-back conversions with no gap cycle.
- bcd and overflow never change except on the done edge or reset. No intermediate values are visible.
- Reset mid-conversion aborts immediately: bcd=0, and no done pulse is ever produced for the aborted request.
- Counter width is clog2(BIN_W). Scratch width is 4*DIGITS. Bits shifted out of the top digit are discarded, which is why saturation exists.

Decomposition:
- Shared package (the display/seven-segment package) holds:
  - DIGIT_W=4
  - ADJ_THRESH=4'd5, ADJ_ADD=4'd3
  - the state encoding enum {IDLE, CONVERT}
- One natural sub-module: bcd_digit_adjust. It is combinational, 4-bit in and 4-bit out, and adds 3 when the digit is >= 5. It is instantiated DIGITS times by a generate loop.
- The FSM, counter and registers stay in the top.

Test Plan:
1. Reset then start with bin=0 -> done after 14 cycles, bcd=16'h0000, overflow=0; busy high for exactly 14 cycles.
2. bin=1234 -> bcd=16'h1234. Then bin=9999 -> bcd=16'h9999, overflow=0. Then bin=7, started in the same cycle the previous done=1 -> bcd=16'h0007 with no idle gap.
3. bin=10000 (and 16383) -> bcd=16'h9999, overflow=1. A following bin=42 -> bcd=16'h0042, overflow=0.
4. Start bin=500, then pulse start with bin=321 and change bin mid-conversion -> exactly one done; bcd=16'h0500; the second start is ignored.
5. Start bin=8765 and assert rst at cycle 6 -> busy=0, bcd=0 immediately, and no done within 20 cycles. A new start bin=8765 after reset release -> bcd=16'h8765.
6. Random sweep of 0..16383 against a reference model -> bcd matches decimal (saturated above 9999) and latency is always 14.
